// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The halt instruction value is only decoded when FETCH_HALT_DETECT_EN is defined.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int          DEF_ADDR_W = 16;
  localparam int          DEF_DATA_W = 16;
  localparam logic [15:0] END_INSTR  = 16'hF000;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instruction} between the memory response and decode.
// Flush wins over push and pop; the head is always presented on the outputs.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_instr,
  input  logic              pop,
  input  logic              flush,
  output logic [1:0]        count,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_instr
);

  logic [ADDR_W-1:0] pc_q    [2];
  logic [DATA_W-1:0] instr_q [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop & (count != 2'd0);
  assign do_push = push & ((count != 2'd2) | do_pop);

  assign head_pc    = pc_q[rd_ptr];
  assign head_instr = instr_q[rd_ptr];

  // NOTE: the storage is reset too, because the head drives ins_out/ins_pc and those have defined reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q[0]    <= '0;
      pc_q[1]    <= '0;
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        pc_q[wr_ptr]    <= push_pc;
        instr_q[wr_ptr] <= push_instr;
        wr_ptr          <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch initiator: owns the PC, issues single-cycle memory reads and buffers responses for decode.
// Define FETCH_HALT_DETECT_EN to stop fetching after the END_INSTR word has been captured.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [DATA_W-1:0] ins_out,
  output logic [ADDR_W-1:0] ins_pc,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              halted
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] last_addr;
  logic              in_flight;
  logic [1:0]        count;
  logic              redirect;
  logic              pop;
  logic              push;
  logic              issue;
  logic              discard;
  logic              halt_pending;
  logic              halt_done;

  // A start while running behaves exactly like a jump to RESET_PC.
  assign redirect = jump | (start & (state == RUN));
  assign pop      = ins_valid & ins_ready;
  assign push     = in_flight & ~discard & ~redirect;

  // Occupancy after this cycle (buffered + returning - leaving) must leave room for the new read.
  assign issue = (state == RUN) & ~stop & ~redirect & ~halt_pending &
                 (({1'b0, count} + {2'b0, in_flight}) < (3'd2 + {2'b0, pop}));

  assign mem_read  = issue;
  assign mem_addr  = issue ? pc : last_addr;
  assign ins_valid = (count != 2'd0);

  fetch_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_pc    (last_addr),
    .push_instr (mem_data),
    .pop        (pop),
    .flush      (redirect),
    .count      (count),
    .head_pc    (ins_pc),
    .head_instr (ins_out)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      last_addr <= RESET_PC;
      in_flight <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) last_addr <= pc;
      case (state)
        RUN: begin
          if (jump)           pc <= jump_addr;
          else if (start)     pc <= RESET_PC;
          else if (halt_done) state <= HALT;
          else if (issue)     pc <= pc + ADDR_W'(1);
        end
        default: begin
          if (jump) begin
            pc <= jump_addr;
          end else if (start) begin
            pc    <= RESET_PC;
            state <= RUN;
          end
        end
      endcase
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  logic halt_hit;

  // The read issued in the same cycle END_INSTR is captured must be dropped on return.
  assign halt_hit  = push & (mem_data == DATA_W'(END_INSTR));
  assign halt_done = halt_pending & (count == 2'd0) & ~in_flight;
  assign halted    = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_pending <= 1'b0;
      discard      <= 1'b0;
    end else begin
      discard <= halt_hit;
      if (redirect || state != RUN) halt_pending <= 1'b0;
      else if (halt_hit)            halt_pending <= 1'b1;
    end
  end
`else
  assign discard      = 1'b0;
  assign halt_pending = 1'b0;
  assign halt_done    = 1'b0;
  assign halted       = 1'b0;
`endif

endmodule
